// File: rtl/vending_machine_def.sv
// Shared vending definitions: coin values, item prices, sizes and state encoding.
package vending_machine_def;

  localparam int unsigned kNumCoins  = 3;
  localparam int unsigned kNumItems  = 4;
  localparam int unsigned kTotalBits = 31;
  localparam int unsigned kTimeout   = 100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  // Coin value for coin bit idx (100 / 500 / 1000).
  function automatic int unsigned coin_value(input int idx);
    case (idx)
      0:       return 100;
      1:       return 500;
      default: return 1000;
    endcase
  endfunction

  // Price for item bit idx (400 / 500 / 1000 / 2000).
  function automatic int unsigned item_price(input int idx);
    case (idx)
      0:       return 400;
      1:       return 500;
      2:       return 1000;
      default: return 2000;
    endcase
  endfunction

endpackage

// File: rtl/change_selector.sv
// Greedy change picker: largest coin not exceeding the total, as one-hot plus value.
module change_selector #(
  parameter int unsigned kTotalBits = vending_machine_def::kTotalBits
) (
  input  logic [kTotalBits-1:0]                    total,
  output logic [vending_machine_def::kNumCoins-1:0] coin,
  output logic [kTotalBits-1:0]                    value
);

  localparam int unsigned kNumCoins = vending_machine_def::kNumCoins;

  logic found;

  // Scan coins from largest to smallest, keep the first that fits.
  always_comb begin
    coin  = '0;
    value = '0;
    found = 1'b0;
    for (int i = int'(kNumCoins) - 1; i >= 0; i--) begin
      if (!found && (total >= kTotalBits'(vending_machine_def::coin_value(i)))) begin
        found = 1'b1;
        coin  = kNumCoins'(1) << i;
        value = kTotalBits'(vending_machine_def::coin_value(i));
      end
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: coin accumulation, item purchase, timeout and greedy change return.
module vend_sequencer #(
  parameter int unsigned kTotalBits = vending_machine_def::kTotalBits,
  parameter int unsigned kTimeout   = vending_machine_def::kTimeout
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [vending_machine_def::kNumCoins-1:0] i_coin,
  input  logic [vending_machine_def::kNumItems-1:0] i_select,
  input  logic                                      i_trigger_return,
  output logic [vending_machine_def::kNumItems-1:0] o_available_item,
  output logic [vending_machine_def::kNumItems-1:0] o_output_item,
  output logic [vending_machine_def::kNumCoins-1:0] o_return_coin,
  output logic [kTotalBits-1:0]                     o_current_total
);

  localparam int unsigned kNumCoins  = vending_machine_def::kNumCoins;
  localparam int unsigned kNumItems  = vending_machine_def::kNumItems;
  localparam int unsigned kSumBits   = kTotalBits + 1;
  localparam int unsigned kTimerBits = $clog2(kTimeout + 1);

  vending_machine_def::state_t state, state_next;
  logic [kTotalBits-1:0] total, total_next, work, price, chg_value;
  logic [kTimerBits-1:0] timer, timer_next;
  logic [kNumItems-1:0]  item_next, sel_onehot;
  logic [kNumCoins-1:0]  ret_next, chg_coin;
  logic [kSumBits-1:0]   coin_sum, gross;
  logic                  coin_ok, sel_hit, buy;

  change_selector #(.kTotalBits(kTotalBits)) u_change (
    .total (total),
    .coin  (chg_coin),
    .value (chg_value)
  );

  // Sum this cycle's coins one bit wider than the total so overflow is visible.
  always_comb begin
    coin_sum = '0;
    for (int i = 0; i < int'(kNumCoins); i++) begin
      if (i_coin[i]) coin_sum = coin_sum + kSumBits'(vending_machine_def::coin_value(i));
    end
    gross   = {1'b0, total} + coin_sum;
    coin_ok = (|i_coin) && !gross[kTotalBits];
  end

  // Lowest-index select wins; affordability is judged on the pre-coin total.
  always_comb begin
    sel_hit    = 1'b0;
    sel_onehot = '0;
    price      = '0;
    for (int i = int'(kNumItems) - 1; i >= 0; i--) begin
      if (i_select[i]) begin
        sel_hit    = 1'b1;
        sel_onehot = kNumItems'(1) << i;
        price      = kTotalBits'(vending_machine_def::item_price(i));
      end
    end
    buy = sel_hit && (price <= total);
  end

  // Items affordable with the registered total.
  always_comb begin
    o_available_item = '0;
    for (int i = 0; i < int'(kNumItems); i++) begin
      o_available_item[i] = (total >= kTotalBits'(vending_machine_def::item_price(i)));
    end
  end

  // Next state, total, timer and output pulses.
  always_comb begin
    state_next = state;
    total_next = total;
    timer_next = timer;
    item_next  = '0;
    ret_next   = '0;
    work       = total;
    case (state)
      vending_machine_def::ST_IDLE, vending_machine_def::ST_ACTIVE: begin
        if (coin_ok) work = gross[kTotalBits-1:0];
        if (buy) begin
          work      = work - price;
          item_next = sel_onehot;
        end
        total_next = work;
        if (coin_ok || buy) timer_next = kTimerBits'(kTimeout);
        else if (state == vending_machine_def::ST_ACTIVE) timer_next = timer - kTimerBits'(1);
        if (work == '0) state_next = vending_machine_def::ST_IDLE;
        else if ((state == vending_machine_def::ST_ACTIVE) &&
                 (i_trigger_return || (timer_next == '0)))
          state_next = vending_machine_def::ST_RETURN;
        else state_next = vending_machine_def::ST_ACTIVE;
      end
      vending_machine_def::ST_RETURN: begin
        timer_next = kTimerBits'(kTimeout);
        if (total == '0) state_next = vending_machine_def::ST_IDLE;
        else if (chg_coin == '0) total_next = '0;
        else begin
          ret_next   = chg_coin;
          total_next = total - chg_value;
        end
      end
      default: state_next = vending_machine_def::ST_IDLE;
    endcase
  end

  // State, total, timer and registered output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= vending_machine_def::ST_IDLE;
      total         <= '0;
      timer         <= kTimerBits'(kTimeout);
      o_output_item <= '0;
      o_return_coin <= '0;
    end else begin
      state         <= state_next;
      total         <= total_next;
      timer         <= timer_next;
      o_output_item <= item_next;
      o_return_coin <= ret_next;
    end
  end

  assign o_current_total = total;

endmodule
